// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-requester round-robin arbiter in front of a single-port RAM
//
// Purpose: lets two requesters share one single-port RAM at one access per
// cycle. Grants are combinational from the requests and a 1-bit priority
// register. Each grant produces a completion pulse (mK_rvalid) one cycle later,
// and read data is steered back to the requester that issued the read.
//
// Ports:
//   clk, rst_i                          clock, synchronous active-high reset
//   mK_req/we/addr/wdata/be   (K=0,1)   requester K access request and fields
//   mK_gnt                              requester K access issued this cycle
//   mK_rvalid, mK_rdata                 requester K completion and read data
//   ram_en/we/addr/wdata/be             single-port RAM command
//   ram_rdata                           RAM read data, valid the cycle after ram_en
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  logic prio_q, prio_d;
  logic rvalid0_q, rvalid1_q;
  logic rd0_q, rd1_q;

  // Grant and RAM command mux. Reset masks grants so nothing reaches the RAM.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    prio_d    = prio_q;
    if (!rst_i) begin
      // m0 wins when alone, or when both request and prio points at it.
      if (m0_req && (!m1_req || !prio_q)) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
    if (m0_gnt) begin
      ram_en    = 1'b1;
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_be    = m0_be;
      prio_d    = 1'b1;
    end else if (m1_gnt) begin
      ram_en    = 1'b1;
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_be    = m1_be;
      prio_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd0_q     <= 1'b0;
      rd1_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rvalid0_q <= m0_gnt;
      rvalid1_q <= m1_gnt;
      // Read flag qualifies rdata so write completions return zero.
      rd0_q     <= m0_gnt & ~m0_we;
      rd1_q     <= m1_gnt & ~m1_we;
    end
  end

  // Completions are masked during reset, which also drops an access granted
  // the cycle before reset was raised.
  always_comb begin
    m0_rvalid = rvalid0_q & ~rst_i;
    m1_rvalid = rvalid1_q & ~rst_i;
    m0_rdata  = (m0_rvalid && rd0_q) ? ram_rdata : '0;
    m1_rdata  = (m1_rvalid && rd1_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - self-checking bench for sp_ram_arbiter
module tb_sp_ram_arbiter;

  logic        clk;
  logic        rst_i;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_be;

  sp_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_i(rst_i),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: read data appears the cycle after ram_en.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
    end
  end

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  int          prio_m;
  int          checks;
  int          failures;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs were set just after the previous edge; check, then advance.
  task automatic tick();
    exp_t        e;
    int          g;
    logic        v0, v1, xwe;
    logic [31:0] d0, d1, xwd;
    logic [7:0]  xa;
    logic [3:0]  xbe;
    #1;
    v0 = 0; v1 = 0; d0 = '0; d1 = '0;
    if (rst_i) begin
      sb.delete();
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port == 0) begin v0 = 1; d0 = e.data; end
      else begin v1 = 1; d1 = e.data; end
    end
    chk("m0_rvalid", m0_rvalid, v0);
    chk("m1_rvalid", m1_rvalid, v1);
    chk("m0_rdata", m0_rdata, d0);
    chk("m1_rdata", m1_rdata, d1);

    g = -1;
    if (!rst_i) begin
      if (m0_req && (!m1_req || prio_m == 0)) g = 0;
      else if (m1_req) g = 1;
    end
    xwe = 0; xa = '0; xwd = '0; xbe = '0;
    if (g == 0) begin xwe = m0_we; xa = m0_addr; xwd = m0_wdata; xbe = m0_be; end
    if (g == 1) begin xwe = m1_we; xa = m1_addr; xwd = m1_wdata; xbe = m1_be; end
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    chk("ram_en", ram_en, g >= 0);
    chk("ram_we", ram_we, xwe);
    chk("ram_addr", ram_addr, xa);
    chk("ram_wdata", ram_wdata, xwd);
    chk("ram_be", ram_be, xbe);
    if (g >= 0) begin
      e.port = g;
      e.data = xwe ? 32'h0 : ref_mem[xa];
      sb.push_back(e);
      if (xwe) ref_mem[xa] = merge(ref_mem[xa], xwd, xbe);
      prio_m = 1 - g;
    end
    if (rst_i) prio_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(logic req, logic we, logic [7:0] a, logic [31:0] d, logic [3:0] be);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic set1(logic req, logic we, logic [7:0] a, logic [31:0] d, logic [3:0] be);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  initial begin
    checks = 0; failures = 0; prio_m = 0;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ram_rdata = '0;

    // Reset with both requesting: no grants, no completions.
    rst_i = 1;
    set0(1, 1, 8'h01, 32'h11111111, 4'hF);
    set1(1, 1, 8'h02, 32'h22222222, 4'hF);
    tick();
    tick();
    rst_i = 0;

    // m0 write DEADBEEF to 0x05, then m1 reads it back.
    set0(1, 1, 8'h05, 32'hDEADBEEF, 4'hF);
    set1(0, 0, 8'h00, 32'h0, 4'h0);
    tick();
    set0(0, 0, 8'h00, 32'h0, 4'h0);
    set1(1, 0, 8'h05, 32'h0, 4'hF);
    tick();
    set1(0, 0, 8'h00, 32'h0, 4'h0);
    tick();

    // Partial byte write then read: expect DEADABEF.
    set0(1, 1, 8'h05, 32'h0000AB00, 4'h2);
    tick();
    set0(1, 0, 8'h05, 32'h0, 4'hF);
    tick();
    set0(0, 0, 8'h00, 32'h0, 4'h0);
    tick();

    // Reset, then both request continuously: 0,1,0,1,0,1.
    rst_i = 1;
    tick();
    rst_i = 0;
    for (int i = 0; i < 6; i++) begin
      set0(1, i[0], 8'h10 + 8'(i), 32'hA0000000 + i, 4'hF);
      set1(1, ~i[0], 8'h05, 32'hB0000000 + i, 4'h5);
      tick();
    end
    set0(0, 0, 8'h00, 32'h0, 4'h0);
    set1(0, 0, 8'h00, 32'h0, 4'h0);
    tick();

    // Random traffic over a small address window.
    for (int i = 0; i < 40; i++) begin
      set0($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      set1($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      tick();
    end

    // Grant, then reset the next cycle: the completion is dropped.
    set0(1, 0, 8'h05, 32'h0, 4'hF);
    set1(1, 0, 8'h03, 32'h0, 4'hF);
    tick();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    tick();
    tick();
    set0(0, 0, 8'h00, 32'h0, 4'h0);
    set1(0, 0, 8'h00, 32'h0, 4'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
